// File: rtl/aio_save_chram_if.sv
// Bus bundle between the channel-RAM saver, the channel RAM and the EEPROM writer.
// The slave modport is the saver's view; master is the environment's view.
interface aio_save_chram_if;
  logic        save_chram_en;
  logic        save_chram_done;
  logic        save_chram_error;
  logic        save_chram_rden;
  logic [11:0] save_chram_addr;
  logic [7:0]  save_chram_rdata;
  logic        chram_eep_wren;
  logic [16:0] chram_eep_length;
  logic [15:0] chram_eep_addr;
  logic        save_eep_valid;
  logic        save_eep_ready;
  logic        save_eep_last;
  logic [7:0]  save_eep_data;
  logic        eep_wr_done;
  logic        eep_wr_error;

  modport slave (
    input  save_chram_en, save_chram_rdata, save_eep_ready, eep_wr_done, eep_wr_error,
    output save_chram_done, save_chram_error, save_chram_rden, save_chram_addr,
           chram_eep_wren, chram_eep_length, chram_eep_addr,
           save_eep_valid, save_eep_last, save_eep_data
  );

  modport master (
    output save_chram_en, save_chram_rdata, save_eep_ready, eep_wr_done, eep_wr_error,
    input  save_chram_done, save_chram_error, save_chram_rden, save_chram_addr,
           chram_eep_wren, chram_eep_length, chram_eep_addr,
           save_eep_valid, save_eep_last, save_eep_data
  );
endinterface

// File: rtl/aio_save_chram.sv
// Streams the channel RAM to the EEPROM writer as byte pairs {data, popcount<<4},
// holding the EEPROM write request for the whole job and aborting on error or stall.
module aio_save_chram #(
  parameter logic [15:0] PARA_ADDR = 16'h800,
  parameter logic [16:0] PARA_LEN  = 17'h1100,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input  logic           sys_clk,
  input  logic           glbl_rst,
  aio_save_chram_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_RD     = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SEND_D = 3'd4;
  localparam logic [2:0] S_SEND_C = 3'd5;
  localparam logic [2:0] S_FLUSH  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [11:0] LAST_IDX = 12'((PARA_LEN >> 1) - 17'd1);

  logic [2:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  sum_q, sum_d;
  logic [15:0] stall_q, stall_d;
  logic        wren_q, wren_d;
  logic        error_q, error_d;
  logic        xfer, last_ent, stalled, abort;

  function automatic logic [3:0] popcnt8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, b[i]};
    return n;
  endfunction

  assign last_ent = (cnt_q == LAST_IDX);
  assign xfer     = bus.save_eep_valid && bus.save_eep_ready;
  // A cycle without forward progress in a state that waits on the EEPROM side.
  assign stalled  = ((state_q == S_SEND_D || state_q == S_SEND_C) && !xfer) ||
                    (state_q == S_FLUSH && !bus.eep_wr_done);
  assign abort    = (state_q != S_IDLE && bus.eep_wr_error) ||
                    (stalled && stall_q == TIMEOUT - 16'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sum_d   = sum_q;
    stall_d = stall_q;
    wren_d  = wren_q;
    error_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      wren_d  = 1'b0;
      error_d = 1'b1;
      stall_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.save_chram_en) begin
            state_d = S_REQ;
            cnt_d   = '0;
            wren_d  = 1'b1;
          end
        end
        S_REQ:  state_d = S_RD;
        S_RD:   state_d = S_WAIT;
        S_WAIT: begin
          data_d  = bus.save_chram_rdata;
          sum_d   = popcnt8(bus.save_chram_rdata);
          state_d = S_SEND_D;
        end
        S_SEND_D: if (xfer) state_d = S_SEND_C;
        S_SEND_C: begin
          if (xfer) begin
            if (last_ent) begin
              state_d = S_FLUSH;
            end else begin
              cnt_d   = cnt_q + 12'd1;
              state_d = S_RD;
            end
          end
        end
        S_FLUSH: begin
          if (bus.eep_wr_done) begin
            state_d = S_DONE;
            wren_d  = 1'b0;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (state_d != state_q || xfer) stall_d = '0;
      else if (stalled)               stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      stall_q <= '0;
      wren_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      stall_q <= stall_d;
      wren_q  <= wren_d;
      error_q <= error_d;
    end
  end

  assign bus.save_chram_rden  = (state_q == S_RD);
  assign bus.save_chram_addr  = cnt_q;
  assign bus.save_chram_done  = (state_q == S_DONE);
  assign bus.save_chram_error = error_q;
  assign bus.chram_eep_wren   = wren_q;
  assign bus.chram_eep_length = wren_q ? PARA_LEN : 17'd0;
  assign bus.chram_eep_addr   = wren_q ? PARA_ADDR : 16'd0;
  assign bus.save_eep_valid   = (state_q == S_SEND_D) || (state_q == S_SEND_C);
  assign bus.save_eep_last    = (state_q == S_SEND_C) && last_ent;
  assign bus.save_eep_data    = (state_q == S_SEND_D) ? data_q :
                                (state_q == S_SEND_C) ? {sum_q, 4'h0} : 8'h00;

endmodule

// File: tb/tb_aio_save_chram.sv
// Bench for aio_save_chram: 4-entry image (PARA_LEN=8), TIMEOUT=16, byte stream
// compared against a queue built from the RAM contents.
module tb_aio_save_chram;

  localparam int          NENT  = 4;
  localparam int          LIMIT = 2000;
  localparam logic [15:0] PADDR = 16'h0800;

  logic clk;
  logic glbl_rst;
  aio_save_chram_if bif();

  aio_save_chram #(
    .PARA_ADDR(PADDR),
    .PARA_LEN (17'd8),
    .TIMEOUT  (16'd16)
  ) dut (
    .sys_clk (clk),
    .glbl_rst(glbl_rst),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram [4096];
  logic [8:0]  obs_q[$];
  logic [8:0]  exp_q[$];
  int          done_cnt, err_cnt, stall_n, zrun;
  int          ready_mode;
  logic [1:0]  ph;
  logic [3:0]  pat = 4'b1001;
  logic        rd_pend;
  logic [11:0] rd_addr;
  logic        prv_stall, rst_prv, err_valid, err_wren;
  logic [7:0]  prv_data;
  logic        prv_last;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    if (bif.save_eep_valid && bif.save_eep_ready)
      obs_q.push_back({bif.save_eep_last, bif.save_eep_data});
    if (bif.save_eep_last) chk_eq("last_with_valid", 32'(bif.save_eep_valid), 32'd1);
    if (prv_stall && !rst_prv && !bif.save_chram_error) begin
      chk_eq("hold_valid", 32'(bif.save_eep_valid), 32'd1);
      chk_eq("hold_data", 32'(bif.save_eep_data), 32'(prv_data));
      chk_eq("hold_last", 32'(bif.save_eep_last), 32'(prv_last));
    end
    if (bif.save_eep_valid) begin
      chk_eq("wren_in_stream", 32'(bif.chram_eep_wren), 32'd1);
      chk_eq("len_in_stream", 32'(bif.chram_eep_length), 32'd8);
      if (!bif.save_eep_ready) stall_n++;
    end
    if (bif.save_chram_done) done_cnt++;
    if (bif.save_chram_error) begin
      err_cnt++;
      err_valid = bif.save_eep_valid;
      err_wren  = bif.chram_eep_wren;
    end
    if (bif.save_chram_done || bif.save_chram_error)
      chk_eq("done_err_excl", 32'(bif.save_chram_done & bif.save_chram_error), 32'd0);
    prv_stall = bif.save_eep_valid && !bif.save_eep_ready;
    prv_data  = bif.save_eep_data;
    prv_last  = bif.save_eep_last;
    rst_prv   = glbl_rst;
    rd_pend   = bif.save_chram_rden;
    rd_addr   = bif.save_chram_addr;
  endtask

  task automatic drive();
    case (ready_mode)
      0: bif.save_eep_ready = 1'b1;
      1: begin bif.save_eep_ready = pat[ph]; ph = ph + 2'd1; end
      2: begin
        if (zrun >= 4) bif.save_eep_ready = 1'b1;
        else           bif.save_eep_ready = ($urandom_range(0, 2) != 0);
        zrun = bif.save_eep_ready ? 0 : zrun + 1;
      end
      default: bif.save_eep_ready = 1'b0;
    endcase
    bif.save_chram_rdata = rd_pend ? ram[rd_addr] : 8'($urandom);
  endtask

  // One clock: observe at the falling edge, update inputs just after the rising edge.
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic check_quiet(input string pfx);
    chk_eq({pfx, "_valid"}, 32'(bif.save_eep_valid), 32'd0);
    chk_eq({pfx, "_last"},  32'(bif.save_eep_last), 32'd0);
    chk_eq({pfx, "_data"},  32'(bif.save_eep_data), 32'd0);
    chk_eq({pfx, "_wren"},  32'(bif.chram_eep_wren), 32'd0);
    chk_eq({pfx, "_len"},   32'(bif.chram_eep_length), 32'd0);
    chk_eq({pfx, "_eaddr"}, 32'(bif.chram_eep_addr), 32'd0);
    chk_eq({pfx, "_rden"},  32'(bif.save_chram_rden), 32'd0);
    chk_eq({pfx, "_done"},  32'(bif.save_chram_done), 32'd0);
    chk_eq({pfx, "_error"}, 32'(bif.save_chram_error), 32'd0);
  endtask

  function automatic void build_exp();
    logic [7:0] cb;
    exp_q.delete();
    for (int i = 0; i < NENT; i++) begin
      cb = 8'($countones(ram[i]) * 16);
      exp_q.push_back({1'b0, ram[i]});
      exp_q.push_back({(i == NENT - 1), cb});
    end
  endfunction

  task automatic cmp_stream(input string pfx, input int n);
    chk_eq({pfx, "_count"}, 32'(obs_q.size()), 32'(n));
    for (int i = 0; i < n && i < obs_q.size(); i++)
      chk_eq($sformatf("%s_byte%0d", pfx, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_job(input int rmode, input int ddly, input int en_at,
                         input int err_at, input int rst_at);
    int guard;
    bit hit_rst;
    obs_q.delete();
    done_cnt = 0; err_cnt = 0; stall_n = 0; zrun = 0; ph = 2'd0;
    ready_mode = rmode;
    build_exp();
    bif.save_chram_en = 1'b1;
    step();
    bif.save_chram_en = 1'b0;
    chk_eq("req_wren", 32'(bif.chram_eep_wren), 32'd1);
    chk_eq("req_len", 32'(bif.chram_eep_length), 32'd8);
    chk_eq("req_eaddr", 32'(bif.chram_eep_addr), 32'(PADDR));
    guard = 0;
    hit_rst = 0;
    while (!(obs_q.size() > 0 && obs_q[$][8]) && err_cnt == 0 && !hit_rst && guard < LIMIT) begin
      if (bif.save_eep_valid && obs_q.size() == en_at)  bif.save_chram_en = 1'b1;
      if (bif.save_eep_valid && obs_q.size() == err_at) bif.eep_wr_error = 1'b1;
      if (bif.save_eep_valid && obs_q.size() == rst_at) glbl_rst = 1'b1;
      step();
      bif.save_chram_en = 1'b0;
      bif.eep_wr_error  = 1'b0;
      if (glbl_rst) begin
        glbl_rst = 1'b0;
        hit_rst  = 1;
        check_quiet("midrst");
        chk_eq("midrst_addr", 32'(bif.save_chram_addr), 32'd0);
      end
      guard++;
    end
    if (guard >= LIMIT) chk_eq("stream_budget", 32'(guard), 32'd0);
    if (err_cnt == 0 && !hit_rst) begin
      repeat (ddly) step();
      bif.eep_wr_done = 1'b1;
      step();
      bif.eep_wr_done = 1'b0;
      guard = 0;
      while (done_cnt == 0 && guard < 20) begin step(); guard++; end
      if (guard >= 20) chk_eq("done_budget", 32'(guard), 32'd0);
    end
    repeat (3) step();
  endtask

  task automatic check_ok(input string pfx);
    cmp_stream(pfx, 2 * NENT);
    chk_eq({pfx, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk_eq({pfx, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk_eq({pfx, "_wren_after"}, 32'(bif.chram_eep_wren), 32'd0);
    chk_eq({pfx, "_len_after"}, 32'(bif.chram_eep_length), 32'd0);
  endtask

  initial begin
    glbl_rst = 1'b1;
    bif.save_chram_en = 1'b0; bif.save_chram_rdata = 8'h00; bif.save_eep_ready = 1'b1;
    bif.eep_wr_done = 1'b0; bif.eep_wr_error = 1'b0;
    ready_mode = 0; ph = 2'd0; zrun = 0; rd_pend = 1'b0; rd_addr = '0;
    prv_stall = 1'b0; rst_prv = 1'b1; prv_data = '0; prv_last = 1'b0;
    err_valid = 1'b0; err_wren = 1'b0; done_cnt = 0; err_cnt = 0; stall_n = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    repeat (3) step();
    check_quiet("reset");
    chk_eq("reset_addr", 32'(bif.save_chram_addr), 32'd0);
    glbl_rst = 1'b0;
    step();

    ram[0] = 8'hFF; ram[1] = 8'h00; ram[2] = 8'hA5; ram[3] = 8'h01;
    run_job(0, 3, -1, -1, -1);
    check_ok("tied");

    run_job(1, 3, -1, -1, -1);
    check_ok("toggle");

    run_job(0, 1, 2, -1, -1);
    check_ok("en_ignored");

    run_job(3, 0, -1, -1, -1);
    chk_eq("to_err_cnt", 32'(err_cnt), 32'd1);
    chk_eq("to_done_cnt", 32'(done_cnt), 32'd0);
    chk_eq("to_stall_cycles", 32'(stall_n), 32'd16);
    chk_eq("to_valid_at_err", 32'(err_valid), 32'd0);
    chk_eq("to_wren_at_err", 32'(err_wren), 32'd0);
    chk_eq("to_bytes", 32'(obs_q.size()), 32'd0);
    check_quiet("to_idle");

    run_job(0, 0, -1, 3, -1);
    chk_eq("werr_err_cnt", 32'(err_cnt), 32'd1);
    chk_eq("werr_done_cnt", 32'(done_cnt), 32'd0);
    chk_eq("werr_valid_at_err", 32'(err_valid), 32'd0);
    chk_eq("werr_wren_at_err", 32'(err_wren), 32'd0);
    cmp_stream("werr", 4);
    check_quiet("werr_idle");

    run_job(0, 0, -1, -1, 5);
    chk_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk_eq("rst_done_cnt", 32'(done_cnt), 32'd0);
    run_job(0, 2, -1, -1, -1);
    check_ok("after_rst");

    // Commit handshakes while idle must be ignored.
    done_cnt = 0; err_cnt = 0;
    bif.eep_wr_error = 1'b1; step(); bif.eep_wr_error = 1'b0;
    bif.eep_wr_done  = 1'b1; step(); bif.eep_wr_done  = 1'b0;
    repeat (3) step();
    chk_eq("idle_err_cnt", 32'(err_cnt), 32'd0);
    chk_eq("idle_done_cnt", 32'(done_cnt), 32'd0);
    check_quiet("idle");

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NENT; i++) ram[i] = 8'($urandom);
      run_job(2, $urandom_range(0, 8), ((k % 2) == 0) ? $urandom_range(0, 7) : -1, -1, -1);
      check_ok($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
